seq_scan_ctrl: RTL and testbench

- Controller that feeds parallel data words into a serial pattern-detection datapath and schedules one scan per word.
- Accepts a word over a valid/ready handshake, shifts it out MSB-first at one bit per cycle, and detects a programmable pattern of 1..PAT_MAX bits in overlapping or non-overlapping mode.
- Counts matches and returns a per-word result over a second valid/ready handshake.
- Sits between the word-oriented fabric and the bit-serial detector stage.

---
 rtl/seq_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_seq_scan_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
// Word-to-serial scan controller: shifts each accepted word out MSB-first, detects a
// programmable 1..PAT_MAX bit pattern on the fly and returns a per-word match count.
module seq_scan_ctrl #(
  parameter int WORD_W  = 16,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  output logic               ser_bit,
  output logic               ser_valid,
  output logic               det,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CNT_W-1:0]   res_count,
  output logic               res_err
);

  localparam int FILL_W = $clog2(PAT_MAX + 1);
  localparam int BIT_W  = $clog2(WORD_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  shreg;
  // Only PAT_MAX-1 past bits are kept: with the incoming bit they form the full window.
  logic [PAT_MAX-2:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [BIT_W-1:0]   bitcnt;
  logic [CNT_W-1:0]   matchcnt;
  logic [PAT_MAX-1:0] pat_q;
  logic [3:0]         len_q;
  logic               ovl_q;
  logic               det_q;
  logic               err_q;

  logic [PAT_MAX-1:0] hist_next;
  logic [PAT_MAX-1:0] mask;
  logic [FILL_W-1:0]  fill_inc;
  logic               match;
  logic               len_bad;
  logic               last_bit;

  assign len_bad   = (cfg_len == 4'd0) || (int'(cfg_len) > PAT_MAX);
  assign last_bit  = (bitcnt == BIT_W'(WORD_W - 1));
  assign hist_next = {hist, shreg[WORD_W-1]};
  assign fill_inc  = (fill == FILL_W'(PAT_MAX)) ? fill : fill + FILL_W'(1);

  always_comb begin
    mask = '0;
    for (int k = 0; k < PAT_MAX; k++) begin
      mask[k] = (k < int'(len_q));
    end
  end

  assign match = (state_q == SHIFT) && (int'(fill_inc) >= int'(len_q)) &&
                 (((hist_next ^ pat_q) & mask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) state_d = len_bad ? DONE : SHIFT;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      hist     <= '0;
      fill     <= '0;
      bitcnt   <= '0;
      matchcnt <= '0;
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b0;
      det_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      det_q <= match;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shreg    <= in_data;
            pat_q    <= cfg_pattern;
            len_q    <= cfg_len;
            ovl_q    <= cfg_overlap;
            hist     <= '0;
            fill     <= '0;
            bitcnt   <= '0;
            matchcnt <= '0;
            err_q    <= len_bad;
          end
        end
        SHIFT: begin
          shreg  <= {shreg[WORD_W-2:0], 1'b0};
          hist   <= hist_next[PAT_MAX-2:0];
          bitcnt <= bitcnt + BIT_W'(1);
          if (match) begin
            if (matchcnt != '1) matchcnt <= matchcnt + CNT_W'(1);
            fill <= ovl_q ? fill_inc : '0;
          end else begin
            fill <= fill_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign ser_bit   = ser_valid & shreg[WORD_W-1];
  assign det       = det_q;
  assign res_count = res_valid ? matchcnt : '0;
  assign res_err   = res_valid & err_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: directed words push expected results, a negedge
// monitor checks serial bits, det pulses, latency and the result handshake.
module tb_seq_scan_ctrl;

  localparam int WORD_W  = 16;
  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PAT_MAX-1:0] cfg_pattern = '0;
  logic [3:0]         cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data = '0;
  logic               ser_bit;
  logic               ser_valid;
  logic               det;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [CNT_W-1:0]   res_count;
  logic               res_err;

  always #5 clk = ~clk;

  seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .det(det),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_err(res_err)
  );

  typedef struct {
    logic [WORD_W-1:0] word;
    int                count;
    logic              err;
    int                dets;
    int                lat;
    int                nser;
  } item_t;

  item_t expQ[$];
  int checks = 0;
  int passes = 0;
  int pushed = 0;
  int popped = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Monitor: tracks the word in flight and compares against the head of the queue.
  logic  busy = 1'b0;
  logic  seenDone = 1'b0;
  int    lat, dets, nser;
  item_t cur;
  logic  expBit;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0;
    end else if (busy) begin
      lat++;
      if (det) dets++;
      if (expQ.size() > 0) begin
        cur = expQ[0];
        if (ser_valid) begin
          expBit = (nser < WORD_W) ? cur.word[WORD_W-1-nser] : 1'bx;
          checkOutput("ser_bit", {31'd0, ser_bit}, {31'd0, expBit});
          nser++;
        end
        if (res_valid) begin
          if (!seenDone) begin
            seenDone = 1'b1;
            checkOutput("latency", lat, cur.lat);
          end
          checkOutput("res_count", {27'd0, res_count}, cur.count);
          checkOutput("res_err", {31'd0, res_err}, {31'd0, cur.err});
          checkOutput("in_ready_done", {31'd0, in_ready}, 0);
          checkOutput("ser_valid_done", {31'd0, ser_valid}, 0);
          if (res_ready) begin
            checkOutput("det_pulses", dets, cur.dets);
            checkOutput("ser_cycles", nser, cur.nser);
            void'(expQ.pop_front());
            popped++;
            busy = 1'b0;
          end
        end
      end
    end else if (in_valid && in_ready) begin
      busy = 1'b1;
      lat = 0;
      dets = 0;
      nser = 0;
      seenDone = 1'b0;
    end
  end

  task automatic waitAccept(output logic acc);
    int n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 0);
    checkOutput({tag, "_ser_bit"}, {31'd0, ser_bit}, 0);
    checkOutput({tag, "_ser_valid"}, {31'd0, ser_valid}, 0);
    checkOutput({tag, "_det"}, {31'd0, det}, 0);
    checkOutput({tag, "_res_valid"}, {31'd0, res_valid}, 0);
    checkOutput({tag, "_res_count"}, {27'd0, res_count}, 0);
    checkOutput({tag, "_res_err"}, {31'd0, res_err}, 0);
  endtask

  task automatic applyStimulus(input logic [WORD_W-1:0] word, input logic [PAT_MAX-1:0] pat,
                               input logic [3:0] len, input logic ovl, input int expCount,
                               input logic expErr, input int expDets, input int holdCycles);
    item_t it;
    logic  acc;
    int    n;
    it.word  = word;
    it.count = expCount;
    it.err   = expErr;
    it.dets  = expDets;
    it.lat   = expErr ? 1 : WORD_W + 1;
    it.nser  = expErr ? 0 : WORD_W;
    expQ.push_back(it);
    pushed++;
    in_data     = word;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    in_valid    = 1'b1;
    res_ready   = 1'b0;
    waitAccept(acc);
    if (!acc) begin
      in_valid = 1'b0;
      return;
    end
    // Scrambled config and data after accept must not affect the word in flight.
    in_valid    = (holdCycles > 0);
    in_data     = ~word;
    cfg_pattern = ~pat;
    cfg_len     = 4'd1;
    cfg_overlap = ~ovl;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 100);
    if (!res_valid) begin
      checkOutput("result_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    repeat (holdCycles) @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    #12;
    checkAllZero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_idle", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;

    applyStimulus(16'hA800, 8'b101, 4'd3, 1'b1, 2, 1'b0, 2, 0);
    applyStimulus(16'hA800, 8'b101, 4'd3, 1'b0, 1, 1'b0, 1, 0);
    applyStimulus(16'hFFFF, 8'b11, 4'd2, 1'b1, 15, 1'b0, 15, 0);
    applyStimulus(16'hFFFF, 8'b11, 4'd2, 1'b0, 8, 1'b0, 8, 0);
    applyStimulus(16'hA5A5, 8'hA5, 4'd8, 1'b1, 2, 1'b0, 2, 0);
    applyStimulus(16'hA800, 8'b101, 4'd0, 1'b1, 0, 1'b1, 0, 0);
    applyStimulus(16'hA800, 8'b101, 4'd9, 1'b1, 0, 1'b1, 0, 0);
    applyStimulus(16'hA800, 8'b101, 4'd3, 1'b1, 2, 1'b0, 2, 5);

    // Abort a word mid-scan; it carries several matches that must not leak forward.
    in_data     = 16'hFFFF;
    cfg_pattern = 8'b11;
    cfg_len     = 4'd2;
    cfg_overlap = 1'b1;
    in_valid    = 1'b1;
    waitAccept(acc);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    checkOutput("abort_in_shift", {31'd0, ser_valid}, 1);
    rst_n = 1'b0;
    #1;
    checkAllZero("abort");
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(16'hA800, 8'b101, 4'd3, 1'b1, 2, 1'b0, 2, 0);

    repeat (3) @(posedge clk);
    checkOutput("queue_empty", expQ.size(), 0);
    checkOutput("results_seen", popped, pushed);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
